// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 fetch front end: instruction size, default
// reset vector, the fetch-queue entry layout and a constant clog2 helper.
package mips_pkg;

    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory bus: pipelined valid/ready requests, in-order responses.
interface mips_fetch_unit_if #(
    parameter int WIDTH = 32
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr;
    logic             resp_valid;
    logic [31:0]      resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );

endinterface

// File: rtl/mips_fetch_queue.sv
// DEPTH-entry synchronous FIFO holding fetched {pc, instr} entries; the head is
// read combinationally so decode sees a pushed entry on the following cycle.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t          storage [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !flush && !reset;
    assign do_pop  = pop && (count != '0) && !flush && !reset;
    assign head    = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= push_entry;
    end

    // The issue credit should make this impossible; firing means lost data.
    assert property (@(posedge clk) disable iff (reset) !(push && !flush && full));

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: credit-limited request issue, in-order response
// capture with PC tagging, and redirect handling that drops stale responses.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                reset,
    mips_fetch_unit_if.master   mem,
    input  logic                redirect,
    input  logic [WIDTH-1:0]    redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [WIDTH-1:0]    out_pc,
    output logic [WIDTH-1:0]    out_pcplus4
);

    localparam int CW  = clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [31:0]      instr;
    } entry_t;

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] resp_pc;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    count;
    logic [CW:0]      credit_sum;
    logic [WIDTH-1:0] target;
    logic             accept;
    logic             push;
    logic             pop;
    entry_t           push_entry;
    entry_t           head;

    // Queued plus in-flight words may never exceed the queue size, so every
    // response always has a slot waiting for it.
    assign credit_sum    = {1'b0, count} + {1'b0, inflight};
    assign mem.req_valid = !reset && !redirect && (credit_sum < CW1'(DEPTH));
    assign mem.req_addr  = fetch_pc;
    assign accept        = mem.req_valid && mem.req_ready;

    assign target     = redirect_pc & ~WIDTH'(3);
    assign push       = mem.resp_valid && !redirect && !reset && (drop_cnt == '0);
    assign push_entry = '{pc: resp_pc, instr: mem.resp_data};

    assign out_valid   = !reset && (count != '0);
    assign pop         = out_valid && out_ready;
    assign out_instr   = head.instr;
    assign out_pc      = head.pc;
    assign out_pcplus4 = head.pc + STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect) begin
            fetch_pc <= target;
            resp_pc  <= target;
            inflight <= inflight - CW'(mem.resp_valid);
            drop_cnt <= inflight - CW'(mem.resp_valid);
        end else begin
            if (accept) fetch_pc <= fetch_pc + STEP;
            inflight <= inflight + CW'(accept) - CW'(mem.resp_valid);
            if (mem.resp_valid) begin
                if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                else                resp_pc  <= resp_pc + STEP;
            end
        end
    end

    mips_fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: fixed-latency memory plus an epoch-tagged model
// of the fetch stream that predicts issue, queue contents and outputs.
module tb_mips_fetch_unit;
    import mips_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;

    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b0;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_pcplus4;

    always #5 clk = ~clk;

    mips_fetch_unit_if #(.WIDTH(32)) mem ();
    mips_fetch_unit_if #(.WIDTH(32)) mem2 ();

    mips_fetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (mem.master),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pcplus4 (out_pcplus4)
    );

    mips_fetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .mem         (mem2.master),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .out_valid   (w_out_valid),
        .out_ready   (w_out_ready),
        .out_instr   (w_out_instr),
        .out_pc      (w_out_pc),
        .out_pcplus4 (w_out_pcplus4)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t       pending[$];
    exp_t        fifo[$];
    int          epoch = 0;
    int          cyc = 0;
    int          lat = 0;
    int          wrap_idx = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_fetch = RST_PC;

    logic        drv_reset;
    logic        drv_redirect;
    logic [31:0] drv_rpc;
    logic        drv_out_ready;
    logic        drv_req_ready;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic apply_stimulus();
        logic  accept;
        logic  resp;
        logic  rv_exp;
        pend_t r;
        r = '{32'h0, 0, 0};
        reset         = drv_reset;
        redirect      = drv_redirect;
        redirect_pc   = drv_rpc;
        out_ready     = drv_out_ready;
        mem.req_ready = drv_req_ready;
        #1;
        rv_exp = !drv_reset && !drv_redirect && ((fifo.size() + pending.size()) < DEPTH);
        check_output("req_valid", {31'b0, mem.req_valid}, {31'b0, rv_exp});
        if (mem.req_valid) check_output("req_addr", mem.req_addr, exp_fetch);
        accept = mem.req_valid && drv_req_ready;
        if (accept) pending.push_back('{mem.req_addr, cyc + lat, epoch});
        resp = !drv_reset && (pending.size() > 0) && (pending[0].due <= cyc);
        mem.resp_valid = resp;
        mem.resp_data  = resp ? mem_word(pending[0].addr) : 32'h0;
        #1;
        check_output("out_valid", {31'b0, out_valid}, {31'b0, (!drv_reset && fifo.size() > 0)});
        if (!drv_reset && fifo.size() > 0) begin
            check_output("out_pc", out_pc, fifo[0].pc);
            check_output("out_instr", out_instr, fifo[0].instr);
            check_output("out_pcplus4", out_pcplus4, fifo[0].pc + 32'd4);
        end
        if (!drv_reset && wrap_idx < 2) begin
            check_output("wrap_req_valid", {31'b0, mem2.req_valid}, 32'd1);
            check_output("wrap_req_addr", mem2.req_addr, (wrap_idx == 0) ? WRAP_PC : 32'h0);
            wrap_idx++;
        end
        @(posedge clk);
        if (drv_reset) begin
            fifo.delete();
            pending.delete();
            epoch++;
            exp_fetch = RST_PC;
        end else begin
            if (resp) r = pending.pop_front();
            if (accept) exp_fetch = exp_fetch + 32'd4;
            if (drv_redirect) begin
                fifo.delete();
                epoch++;
                exp_fetch = drv_rpc & ~32'h3;
            end else begin
                if (drv_out_ready && fifo.size() > 0) void'(fifo.pop_front());
                if (resp && r.epoch == epoch) fifo.push_back('{r.addr, mem_word(r.addr)});
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    task automatic redirect_once(input logic [31:0] pc);
        drv_redirect = 1'b1;
        drv_rpc      = pc;
        apply_stimulus();
        drv_redirect = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        mem.req_ready  = 1'b0;
        mem.resp_valid = 1'b0;
        mem.resp_data  = 32'h0;
        mem2.req_ready  = 1'b1;
        mem2.resp_valid = 1'b0;
        mem2.resp_data  = 32'h0;
        drv_reset     = 1'b1;
        drv_redirect  = 1'b0;
        drv_rpc       = 32'h0;
        drv_out_ready = 1'b1;
        drv_req_ready = 1'b1;
        @(negedge clk);
        run(3);

        $display("[TB] zero-latency streaming");
        drv_reset = 1'b0;
        lat = 0;
        run(12);

        $display("[TB] decode stall fills queue, then drains");
        drv_out_ready = 1'b0;
        run(8);
        drv_out_ready = 1'b1;
        run(8);

        $display("[TB] 3-cycle memory, redirect to 0x100");
        lat = 3;
        run(8);
        redirect_once(32'h0000_0100);
        run(12);

        $display("[TB] redirect colliding with response and pop");
        lat = 1;
        run(6);
        redirect_once(32'h0000_0203);
        run(8);

        $display("[TB] reset with a full queue");
        lat = 0;
        drv_out_ready = 1'b0;
        run(6);
        drv_reset = 1'b1;
        apply_stimulus();
        drv_reset = 1'b0;
        drv_out_ready = 1'b1;
        run(8);

        $display("[TB] address wrap");
        redirect_once(32'hFFFF_FFF4);
        run(10);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) lat = $urandom_range(0, 3);
            drv_req_ready = ($urandom_range(0, 3) != 0);
            drv_out_ready = ($urandom_range(0, 3) != 0);
            drv_redirect  = ($urandom_range(0, 19) == 0);
            drv_rpc       = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFE0 | ($urandom & 32'h1F));
            drv_reset     = ($urandom_range(0, 199) == 0);
            apply_stimulus();
        end
        drv_redirect = 1'b0;
        drv_reset    = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
